// File: rtl/logic_pkg.sv
// Shared op-code definitions for the pipelined bitwise logic unit.
package logic_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOT  = 3'd0;
  localparam logic [OP_W-1:0] OP_AND  = 3'd1;
  localparam logic [OP_W-1:0] OP_OR   = 3'd2;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd3;
  localparam logic [OP_W-1:0] OP_NAND = 3'd4;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
  localparam logic [OP_W-1:0] OP_PASS = 3'd7;

endpackage

// File: rtl/logic_stage.sv
// One pipeline slot: valid/data/zero register with a load enable.
module logic_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  input  logic             src_zero,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             zero
);

  // Valid follows the source whenever enabled; payload only moves with a real
  // item so an emptied slot keeps its last data visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      zero  <= 1'b0;
    end else begin
      if (en) valid <= src_valid;
      if (en && src_valid) begin
        data <= src_data;
        zero <= src_zero;
      end
    end
  end

endmodule

// File: rtl/logic_pipe.sv
// Pipelined bitwise logic unit with valid/ready flow control and bubble
// compression. Result and zero flag are formed at entry, then carried through
// STAGES slots.
module logic_pipe
  import logic_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int STAGES = 2,
  localparam int OCC_W  = $clog2(STAGES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic [OCC_W-1:0] occupancy
);

  // Index 0 is the entry (combinational), 1..STAGES are the registered slots.
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0][WIDTH-1:0] dat_pipe;
  logic [STAGES:0]            zro_pipe;
  logic [STAGES:1]            en;
  logic [WIDTH-1:0]           res;
  logic                       acc, emit;

  // Op decoder feeding the entry slot.
  always_comb begin
    res = in_a;
    case (in_op)
      OP_NOT:  res = ~in_a;
      OP_AND:  res = in_a & in_b;
      OP_OR:   res = in_a | in_b;
      OP_XOR:  res = in_a ^ in_b;
      OP_NAND: res = ~(in_a & in_b);
      OP_NOR:  res = ~(in_a | in_b);
      OP_XNOR: res = ~(in_a ^ in_b);
      default: res = in_a;  // OP_PASS
    endcase
  end

  assign vld_pipe[0] = in_valid;
  assign dat_pipe[0] = res;
  assign zro_pipe[0] = (res == '0);

  // Load chain, computed from the output backwards: a slot may load when it is
  // empty or its own contents move on this cycle.
  always_comb begin
    en = '0;
    en[STAGES] = !vld_pipe[STAGES] || out_ready;
    for (int i = STAGES - 1; i >= 1; i--)
      en[i] = !vld_pipe[i] || en[i+1];
  end

  for (genvar i = 1; i <= STAGES; i++) begin : g_stg
    logic_stage #(.WIDTH(WIDTH)) u_stg (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en[i]),
      .src_valid (vld_pipe[i-1]),
      .src_data  (dat_pipe[i-1]),
      .src_zero  (zro_pipe[i-1]),
      .valid     (vld_pipe[i]),
      .data      (dat_pipe[i]),
      .zero      (zro_pipe[i])
    );
  end

  assign in_ready  = en[1];
  assign out_valid = vld_pipe[STAGES];
  assign out_data  = dat_pipe[STAGES];
  assign out_zero  = zro_pipe[STAGES];
  assign acc       = in_valid && in_ready;
  assign emit      = out_valid && out_ready;

  // Item count: simultaneous accept and emit cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            occupancy <= '0;
    else if (acc && !emit) occupancy <= occupancy + OCC_W'(1);
    else if (emit && !acc) occupancy <= occupancy - OCC_W'(1);
  end

endmodule

// File: tb/tb_logic_pipe.sv
// Bench for logic_pipe: queue-based reference model checked every cycle, plus
// directed vectors with literal expectations.
module tb_logic_pipe;
  import logic_pkg::*;

  localparam int W = 16;
  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n;
  logic                     in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [2:0]               in_op;
  logic [W-1:0]             in_a, in_b, out_data;
  logic [$clog2(S+1)-1:0]   occupancy;

  logic       s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_zero;
  logic [2:0] s_op;
  logic [7:0] s_a, s_b, s_out_data;
  logic [0:0] s_occ;

  logic_pipe #(.WIDTH(W), .STAGES(S)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero),
    .occupancy(occupancy));

  logic_pipe #(.WIDTH(8), .STAGES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_op(s_op), .in_a(s_a), .in_b(s_b), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_data(s_out_data), .out_zero(s_out_zero),
    .occupancy(s_occ));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] op_ref(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0: return ~a;
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return a ^ b;
      3'd4: return ~(a & b);
      3'd5: return ~(a | b);
      3'd6: return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  typedef struct { logic [W-1:0] d; int acc; } item_t;
  typedef struct { logic [W-1:0] d; logic z; int cyc; } rx_t;
  item_t mq[$];
  rx_t   rxq[$];

  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic         prev_zero;

  // Reference model: FIFO of in-flight results, each due S cycles after accept.
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      prev_stall = 1'b0;
    end else begin
      logic exp_ov;
      exp_ov = (mq.size() > 0) && (cyc >= mq[0].acc + S);
      chk("occupancy", 64'(occupancy), 64'(mq.size()));
      chk("out_valid", 64'(out_valid), 64'(exp_ov));
      chk("in_ready", 64'(in_ready), 64'((mq.size() < S) || out_ready));
      if (prev_stall) begin
        chk("stall_data", 64'(out_data), 64'(prev_data));
        chk("stall_zero", 64'(out_zero), 64'(prev_zero));
      end
      if (out_valid && mq.size() > 0) begin
        chk("out_data", 64'(out_data), 64'(mq[0].d));
        chk("out_zero", 64'(out_zero), 64'(mq[0].d == '0));
      end
      if (out_valid && out_ready) begin
        rxq.push_back('{out_data, out_zero, cyc});
        if (mq.size() > 0) void'(mq.pop_front());
      end
      if (in_valid && in_ready) mq.push_back('{op_ref(in_op, in_a, in_b), cyc});
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_zero  = out_zero;
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
    int n = 0;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; acc = -1;
    while (acc < 0 && n < 100) begin
      @(negedge clk);
      if (in_ready) acc = cyc;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (acc < 0) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=no_accept required=accept");
    end
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (mq.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (mq.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d required=0", mq.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_rx(input string name, input int idx, input logic [W-1:0] d, input int c);
    if (idx >= rxq.size()) begin
      chk({name, "_missing"}, 64'(rxq.size()), 64'(idx + 1));
    end else begin
      chk({name, "_data"}, 64'(rxq[idx].d), 64'(d));
      chk({name, "_zero"}, 64'(rxq[idx].z), 64'(d == '0));
      if (c >= 0) chk({name, "_cycle"}, 64'(rxq[idx].cyc), 64'(c));
    end
  endtask

  logic [7:0] va[5] = '{8'hF0, 8'h12, 8'hFF, 8'h00, 8'hA5};
  logic [7:0] vb[5] = '{8'h3C, 8'h34, 8'hFF, 8'h00, 8'h5A};
  logic [7:0] ve[5] = '{8'hCF, 8'hEF, 8'h00, 8'hFF, 8'hFF};

  initial begin
    int a0, a1, a2, base, rel;
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_op = 3'd4; s_a = '0; s_b = '0; s_out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_occupancy", 64'(occupancy), 0);
    chk("rst_out_data", 64'(out_data), 0);
    chk("rst_out_zero", 64'(out_zero), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    @(posedge clk); #1 rst_n = 1'b1;

    // 1: NOT back-to-back, latency 2
    base = rxq.size();
    send(OP_NOT, 16'h0000, 16'h0, a0);
    send(OP_NOT, 16'hFFFF, 16'h0, a1);
    send(OP_NOT, 16'hAAAA, 16'h0, a2);
    chk("t1_b2b_1", 64'(a1), 64'(a0 + 1));
    chk("t1_b2b_2", 64'(a2), 64'(a0 + 2));
    drain();
    chk_rx("t1_r0", base,     16'hFFFF, a0 + 2);
    chk_rx("t1_r1", base + 1, 16'h0000, a0 + 3);
    chk_rx("t1_r2", base + 2, 16'h5555, a0 + 4);

    // 2: remaining ops
    base = rxq.size();
    send(OP_AND,  16'h3CC3, 16'hAAAA, a0);
    send(OP_XOR,  16'h1234, 16'hFFFF, a0);
    send(OP_NOR,  16'h0000, 16'h0000, a0);
    send(OP_PASS, 16'h1234, 16'hBEEF, a0);
    send(OP_OR,   16'h00F0, 16'h0F00, a0);
    send(OP_NAND, 16'hFFFF, 16'h0F0F, a0);
    send(OP_XNOR, 16'h1234, 16'h1234, a0);
    drain();
    chk_rx("t2_and",  base,     16'h2882, -1);
    chk_rx("t2_xor",  base + 1, 16'hEDCB, -1);
    chk_rx("t2_nor",  base + 2, 16'hFFFF, -1);
    chk_rx("t2_pass", base + 3, 16'h1234, -1);
    chk_rx("t2_or",   base + 4, 16'h0FF0, -1);
    chk_rx("t2_nand", base + 5, 16'hF0F0, -1);
    chk_rx("t2_xnor", base + 6, 16'hFFFF, -1);

    // 3: backpressure fills the pipe, third item waits
    base = rxq.size();
    out_ready = 1'b0;
    send(OP_PASS, 16'h0001, 16'h0, a0);
    send(OP_PASS, 16'h0002, 16'h0, a0);
    in_valid = 1'b1; in_op = OP_PASS; in_a = 16'h0003;
    @(negedge clk);
    chk("t3_full_in_ready", 64'(in_ready), 0);
    chk("t3_full_occupancy", 64'(occupancy), 2);
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("t3_third_ready", 64'(in_ready), 1);
    @(posedge clk); #1 in_valid = 1'b0;
    drain();
    chk_rx("t3_r0", base,     16'h0001, -1);
    chk_rx("t3_r1", base + 1, 16'h0002, -1);
    chk_rx("t3_r2", base + 2, 16'h0003, -1);

    // 4: streaming with out_ready toggling every cycle
    base = rxq.size();
    fork
      begin
        repeat (40) begin @(posedge clk); #1 out_ready = ~out_ready; end
      end
      begin
        for (int k = 0; k < 8; k++) send(OP_XOR, 16'(k * 16'h1111), 16'h00FF, a0);
      end
    join
    drain();
    chk("t4_count", 64'(rxq.size() - base), 8);
    for (int k = 0; k < 8; k++)
      chk_rx("t4_item", base + k, 16'(k * 16'h1111) ^ 16'h00FF, -1);

    // 5: reset mid-stream
    out_ready = 1'b0;
    send(OP_PASS, 16'h1111, 16'h0, a0);
    send(OP_PASS, 16'h2222, 16'h0, a0);
    @(negedge clk);
    chk("t5_pre_occupancy", 64'(occupancy), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_out_valid", 64'(out_valid), 0);
    chk("t5_rst_occupancy", 64'(occupancy), 0);
    chk("t5_rst_out_data", 64'(out_data), 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    rel = cyc;
    out_ready = 1'b1;
    base = rxq.size();
    send(OP_PASS, 16'hC0DE, 16'h0, a0);
    chk("t5_first_accept", 64'(a0), 64'(rel));
    drain();
    chk("t5_count", 64'(rxq.size() - base), 1);
    chk_rx("t5_item", base, 16'hC0DE, a0 + 2);

    // 6: WIDTH=8, STAGES=1 NAND stream at full rate
    for (int k = 0; k <= 5; k++) begin
      if (k < 5) begin
        s_in_valid = 1'b1; s_a = va[k]; s_b = vb[k];
      end else begin
        s_in_valid = 1'b0;
      end
      @(negedge clk);
      if (k < 5) chk("t6_in_ready", 64'(s_in_ready), 1);
      if (k > 0) begin
        chk("t6_out_valid", 64'(s_out_valid), 1);
        chk("t6_out_data", 64'(s_out_data), 64'(ve[k-1]));
        chk("t6_out_zero", 64'(s_out_zero), 64'(ve[k-1] == 8'h00));
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("t6_empty_valid", 64'(s_out_valid), 0);
    chk("t6_empty_occ", 64'(s_occ), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
